timer_ctrl: RTL and testbench
=============================

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per countdown tick (minimum 2).
REQ-002 Parameter CNT_W, default 26, prescaler width; SHALL satisfy 2^CNT_W >= TICK_DIV.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 load  input  1  request to reload the digit chain to its maximum value.
REQ-006 start  input  1  begin or resume countdown.
REQ-007 pause  input  1  suspend countdown.
REQ-008 timer_zero  input  1  no-borrow flag from least-significant digit; 1 = chain exhausted.
REQ-009 reconfig  output  1  reload strobe broadcast to every digit.
REQ-010 tick  output  1  one-cycle borrow request into the least-significant digit.
REQ-011 running  output  1  high while in RUN.
REQ-012 timeout  output  1  high while in TIMEOUT.
REQ-013 state  output  3  current FSM state encoding.

Function
REQ-014 State encodings SHALL be IDLE=0, LOAD=1, ARMED=2, RUN=3, PAUSED=4, TIMEOUT=5; codes 6-7 SHALL return to IDLE on the next edge.
REQ-015 All outputs SHALL be registered; no output SHALL depend combinationally on an input.
REQ-016 load=1 SHALL move any state to LOAD on the next edge and clear the prescaler.
REQ-017 reconfig SHALL be 1 in exactly the cycles state==LOAD; LOAD SHALL persist while load stays 1, then go to ARMED.
REQ-018 IDLE: only load is acted on; start and pause are ignored.
REQ-019 ARMED: start=1 SHALL go to RUN with prescaler=0; pause ignored.
REQ-020 RUN: prescaler SHALL increment each cycle, wrapping from TICK_DIV-1 to 0.
REQ-021 RUN: at the edge where prescaler==TICK_DIV-1, tick SHALL be 1 for the following cycle only; first tick SHALL appear TICK_DIV cycles after RUN entry.
REQ-022 RUN: timer_zero=1 SHALL go to TIMEOUT; the tick due at that edge SHALL be suppressed.
REQ-023 RUN: pause=1 SHALL go to PAUSED with prescaler frozen at its current value and no tick issued at that edge.
REQ-024 Priority in RUN SHALL be load > timer_zero > pause > tick generation.
REQ-025 PAUSED: start=1 SHALL return to RUN resuming from the frozen prescaler; start and pause both 1 SHALL remain PAUSED.
REQ-026 TIMEOUT: timeout held 1, tick held 0; only load exits; timer_zero ignored outside RUN.
REQ-027 tick SHALL never be 1 outside the cycle after a RUN-state wrap edge.

Reset
REQ-028 rst=0 at an edge SHALL force state=IDLE, prescaler=0, reconfig=0, tick=0, running=0, timeout=0, overriding every other input.
REQ-029 Reset mid-RUN SHALL discard any pending tick; no tick in the cycle after reset.

Verification (TICK_DIV=4)
REQ-030 rst=0 for 2 cycles with load=start=1 -> all outputs 0, state=0.
REQ-031 1-cycle load in IDLE -> reconfig=1 one cycle, state 1 then 2; start -> running=1, tick on cycles 4, 8, 12 after RUN entry, each 1 cycle wide.
REQ-032 pause after prescaler reaches 2, held 10 cycles -> no tick, state=4; start -> next tick exactly 2 cycles after re-entering RUN.
REQ-033 timer_zero=1 at the edge where prescaler==3 -> tick stays 0, state=5, timeout=1 until load; start ignored.
REQ-034 load during RUN with prescaler==3 -> no tick, state=1, reconfig pulse, running=0; start later -> first tick 4 cycles after RUN entry.
REQ-035 rst=0 one cycle mid-RUN at prescaler==3 -> state=0 next cycle, tick=0, start then ignored until load.

Source files
------------

// File: rtl/timer_ctrl.sv
// Countdown timer controller: run/pause/timeout sequencing and prescaled
// borrow ticks into an external digit chain. All outputs are registered.
module timer_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic       timer_zero,
    output logic       reconfig,
    output logic       tick,
    output logic       running,
    output logic       timeout,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ARMED   = 3'd2,
        RUN     = 3'd3,
        PAUSED  = 3'd4,
        TIMEOUT = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] PRESC_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] PRESC_ONE  = CNT_W'(1);

    logic [2:0]       state_r;
    logic [2:0]       next_state_s;
    logic [CNT_W-1:0] presc_r;
    logic [CNT_W-1:0] presc_next_s;
    logic             tick_next_s;
    logic             reconfig_r;
    logic             tick_r;
    logic             running_r;
    logic             timeout_r;

    // Next-state, prescaler and tick decision; load outranks everything.
    always_comb begin
        next_state_s = state_r;
        presc_next_s = presc_r;
        tick_next_s  = 1'b0;
        if (load) begin
            next_state_s = LOAD;
            presc_next_s = PRESC_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    next_state_s = IDLE;
                end
                LOAD: begin
                    next_state_s = ARMED;
                end
                ARMED: begin
                    if (start) begin
                        next_state_s = RUN;
                        presc_next_s = PRESC_ZERO;
                    end else begin
                        next_state_s = ARMED;
                    end
                end
                RUN: begin
                    if (timer_zero) begin
                        next_state_s = TIMEOUT;
                    end else if (pause) begin
                        // Prescaler frozen so the resumed run keeps its phase.
                        next_state_s = PAUSED;
                    end else if (presc_r == PRESC_LAST) begin
                        presc_next_s = PRESC_ZERO;
                        tick_next_s  = 1'b1;
                    end else begin
                        presc_next_s = presc_r + PRESC_ONE;
                    end
                end
                PAUSED: begin
                    if (start && !pause) begin
                        next_state_s = RUN;
                    end else begin
                        next_state_s = PAUSED;
                    end
                end
                TIMEOUT: begin
                    next_state_s = TIMEOUT;
                end
                default: begin
                    next_state_s = IDLE;
                    presc_next_s = PRESC_ZERO;
                end
            endcase
        end
    end

    // State, prescaler and registered output flags with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            presc_r    <= PRESC_ZERO;
            reconfig_r <= 1'b0;
            tick_r     <= 1'b0;
            running_r  <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            presc_r    <= presc_next_s;
            reconfig_r <= (next_state_s == LOAD);
            tick_r     <= tick_next_s;
            running_r  <= (next_state_s == RUN);
            timeout_r  <= (next_state_s == TIMEOUT);
        end
    end

    assign reconfig = reconfig_r;
    assign tick     = tick_r;
    assign running  = running_r;
    assign timeout  = timeout_r;
    assign state    = state_r;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with TICK_DIV=4.
module tb_timer_ctrl;

    logic       clk;
    logic       rst;
    logic       load;
    logic       start;
    logic       pause;
    logic       timer_zero;
    logic       reconfig;
    logic       tick;
    logic       running;
    logic       timeout;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    timer_ctrl #(.TICK_DIV(4), .CNT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .start(start),
        .pause(pause),
        .timer_zero(timer_zero),
        .reconfig(reconfig),
        .tick(tick),
        .running(running),
        .timeout(timeout),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] e_state, input logic e_reconfig,
                           input logic e_tick, input logic e_running, input logic e_timeout);
        chk({tag, ".state"},    32'(state),    32'(e_state));
        chk({tag, ".reconfig"}, 32'(reconfig), 32'(e_reconfig));
        chk({tag, ".tick"},     32'(tick),     32'(e_tick));
        chk({tag, ".running"},  32'(running),  32'(e_running));
        chk({tag, ".timeout"},  32'(timeout),  32'(e_timeout));
    endtask

    initial begin
        rst = 1'b0; load = 1'b1; start = 1'b1; pause = 1'b0; timer_zero = 1'b0;
        step();
        step();
        chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Load from IDLE, arm, start.
        rst = 1'b1; load = 1'b1; start = 1'b0;
        step();
        chk_all("load1", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        load = 1'b0; pause = 1'b1;
        step();
        chk_all("armed", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("armed_pause_ign", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        pause = 1'b0; start = 1'b1;
        step();
        chk_all("run_entry", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("run_tick_c%0d", k), 32'(tick), 32'((k % 4) == 0));
            chk($sformatf("run_state_c%0d", k), 32'(state), 32'd3);
        end

        // Prescaler reaches 2, then pause for 10 cycles.
        step();
        step();
        pause = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k == 6) start = 1'b1;
            step();
            chk_all($sformatf("paused_c%0d", k), 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        pause = 1'b0; start = 1'b1;
        step();
        chk_all("resume", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        step();
        chk("resume_tick_c1", 32'(tick), 32'd0);
        step();
        chk("resume_tick_c2", 32'(tick), 32'd1);

        // Prescaler back to 3, then timer_zero at the wrap edge.
        step();
        step();
        step();
        timer_zero = 1'b1;
        step();
        chk_all("timeout", 3'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_all($sformatf("timeout_hold_c%0d", k), 3'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        timer_zero = 1'b0; start = 1'b0;

        // Exit TIMEOUT by load, run to prescaler 3, then load mid-RUN.
        load = 1'b1;
        step();
        chk_all("reload", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        load = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        load = 1'b1;
        step();
        chk_all("load_midrun", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("load_held", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        load = 1'b0;
        step();
        chk_all("rearmed", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        step();
        chk("rerun_state", 32'(state), 32'd3);
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("rerun_tick_c%0d", k), 32'(tick), 32'(k == 4));
        end

        // Reset mid-RUN at prescaler 3.
        step();
        step();
        step();
        rst = 1'b0;
        step();
        chk_all("midrun_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1; start = 1'b1; pause = 1'b1; timer_zero = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk_all($sformatf("idle_ignore_c%0d", k), 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
